// File: rtl/mixcol_sched.sv
// -----------------------------------------------------------------------------
// mixcol_sched
// Column scheduler for an AES encryption round. Takes one 128-bit state over a
// valid/ready handshake and streams its four 32-bit columns, one per cycle,
// through a single shared MixColumns column unit. It collects the transformed
// columns as they return and presents the reassembled state downstream. The
// final round uses a bypass that returns the input state untouched.
//
// Parameters:
//   COL_LAT    pipeline latency of the attached column unit (0..3, 0 = comb)
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream state available
//   in_ready   scheduler can accept a state (registered)
//   in_state   128-bit state; column c = in_state[127-32c -: 32]
//   in_bypass  sampled with in_state; 1 = pass state through (final round)
//   col_issue  column unit operand valid this cycle (registered)
//   col_out    column operand to the column unit (registered)
//   col_in     transformed column, valid COL_LAT cycles after its issue
//   out_valid  result state available (registered)
//   out_ready  downstream accepts result
//   out_state  result state, same column ordering as in_state (registered)
//   busy       high whenever the FSM is not IDLE (registered)
// -----------------------------------------------------------------------------
module mixcol_sched #(
   parameter int COL_LAT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_bypass,
   output logic         col_issue,
   output logic [31:0]  col_out,
   input  logic [31:0]  col_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fsm_t;

   fsm_t          r_fsm;
   logic [127:0]  r_lat;
   logic [1:0]    r_ic;
   logic [1:0]    r_rc;
   logic [127:0]  r_result;
   logic          r_in_ready;
   logic          r_col_issue;
   logic [31:0]   r_col_out;
   logic          r_out_valid;
   logic [127:0]  r_out_state;
   logic          r_busy;

   logic          w_accept;
   logic          w_ret;
   logic [1:0]    w_ic_next;
   logic [127:0]  w_result_next;

   // Pick column c of a state, column 0 in the most significant lane.
   function automatic logic [31:0] col_sel(input logic [127:0] s, input logic [1:0] c);
      logic [31:0] v;
      case (c)
         2'd0:    v = s[127:96];
         2'd1:    v = s[95:64];
         2'd2:    v = s[63:32];
         2'd3:    v = s[31:0];
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   assign w_accept  = (r_fsm == IDLE) && in_valid && r_in_ready;
   assign w_ic_next = r_ic + 2'd1;

   // Return strobe: the issue strobe delayed by the column unit latency.
   generate
      if (COL_LAT == 0) begin : g_comb
         assign w_ret = r_col_issue;
      end else begin : g_pipe
         logic [COL_LAT-1:0] r_pipe;

         // Shift register of issue strobes tracking columns inside the unit.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_pipe <= '0;
            end else begin
               r_pipe[0] <= r_col_issue;
               for (int i = 1; i < COL_LAT; i++) begin
                  r_pipe[i] <= r_pipe[i-1];
               end
            end
         end

         assign w_ret = r_pipe[COL_LAT-1];
      end
   endgenerate

   // Result register with the returning column merged into lane rc; used both
   // for the capture and for loading out_state on the capture of column 3.
   always_comb begin
      w_result_next = r_result;
      if (w_ret) begin
         case (r_rc)
            2'd0:    w_result_next[127:96] = col_in;
            2'd1:    w_result_next[95:64]  = col_in;
            2'd2:    w_result_next[63:32]  = col_in;
            2'd3:    w_result_next[31:0]   = col_in;
            default: w_result_next         = r_result;
         endcase
      end else begin
         w_result_next = r_result;
      end
   end

   // Capture returning columns in order; rc restarts with every new state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= 128'd0;
         r_rc     <= 2'd0;
      end else if (w_accept) begin
         r_rc     <= 2'd0;
      end else if (w_ret) begin
         r_result <= w_result_next;
         r_rc     <= r_rc + 2'd1;
      end
   end

   // Scheduler FSM; every output is registered alongside its state transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm       <= IDLE;
         r_lat       <= 128'd0;
         r_ic        <= 2'd0;
         r_in_ready  <= 1'b1;
         r_col_issue <= 1'b0;
         r_col_out   <= 32'd0;
         r_out_valid <= 1'b0;
         r_out_state <= 128'd0;
         r_busy      <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (w_accept) begin
                  r_lat      <= in_state;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  if (in_bypass) begin
                     r_fsm       <= DONE;
                     r_out_valid <= 1'b1;
                     r_out_state <= in_state;
                  end else begin
                     r_fsm       <= ISSUE;
                     r_ic        <= 2'd0;
                     r_col_issue <= 1'b1;
                     r_col_out   <= col_sel(in_state, 2'd0);
                  end
               end
            end
            ISSUE: begin
               r_ic <= w_ic_next;
               if (r_ic == 2'd3) begin
                  r_col_issue <= 1'b0;
                  r_col_out   <= 32'd0;
                  // With a combinational unit column 3 is captured this very
                  // edge, so the result can be loaded straight away.
                  if (COL_LAT == 0) begin
                     r_fsm       <= DONE;
                     r_out_valid <= 1'b1;
                     r_out_state <= w_result_next;
                  end else begin
                     r_fsm <= DRAIN;
                  end
               end else begin
                  r_col_out <= col_sel(r_lat, w_ic_next);
               end
            end
            DRAIN: begin
               if (w_ret && (r_rc == 2'd3)) begin
                  r_fsm       <= DONE;
                  r_out_valid <= 1'b1;
                  r_out_state <= w_result_next;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_fsm       <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_fsm       <= IDLE;
               r_in_ready  <= 1'b1;
               r_col_issue <= 1'b0;
               r_col_out   <= 32'd0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign col_issue = r_col_issue;
   assign col_out   = r_col_out;
   assign out_valid = r_out_valid;
   assign out_state = r_out_state;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mixcol_sched.sv
// -----------------------------------------------------------------------------
// tb_mixcol_sched
// Directed bench for mixcol_sched. Two instances are used: one with a
// combinational column unit (COL_LAT=0) and one with a two-stage unit
// (COL_LAT=2). The column unit itself is a small MixColumns model; expected
// states are the known AES column vectors.
// -----------------------------------------------------------------------------
module tb_mixcol_sched;

   logic         clk;
   logic         rst_n;

   logic         d0_in_valid, d0_in_ready, d0_in_bypass;
   logic [127:0] d0_in_state;
   logic         d0_col_issue;
   logic [31:0]  d0_col_out, d0_col_in;
   logic         d0_out_valid, d0_out_ready;
   logic [127:0] d0_out_state;
   logic         d0_busy;

   logic         d2_in_valid, d2_in_ready, d2_in_bypass;
   logic [127:0] d2_in_state;
   logic         d2_col_issue;
   logic [31:0]  d2_col_out, d2_col_in;
   logic         d2_out_valid, d2_out_ready;
   logic [127:0] d2_out_state;
   logic         d2_busy;
   logic [31:0]  d2_p1, d2_p2;

   int n_checks;
   int n_errors;

   logic [127:0] st_a, ex_a, st_b, ex_b, st_c, ex_c, st_byp;
   logic [127:0] seq_in  [3];
   logic [127:0] seq_exp [3];

   mixcol_sched #(.COL_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d0_in_valid), .in_ready(d0_in_ready),
      .in_state(d0_in_state), .in_bypass(d0_in_bypass),
      .col_issue(d0_col_issue), .col_out(d0_col_out), .col_in(d0_col_in),
      .out_valid(d0_out_valid), .out_ready(d0_out_ready),
      .out_state(d0_out_state), .busy(d0_busy)
   );

   mixcol_sched #(.COL_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .in_state(d2_in_state), .in_bypass(d2_in_bypass),
      .col_issue(d2_col_issue), .col_out(d2_col_out), .col_in(d2_col_in),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready),
      .out_state(d2_out_state), .busy(d2_busy)
   );

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // MixColumns on one column, column byte 0 in bits 31:24.
   function automatic logic [31:0] mixcol(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   assign d0_col_in = mixcol(d0_col_out);

   // Two-stage column unit for the COL_LAT=2 instance.
   always @(posedge clk) begin
      d2_p1 <= mixcol(d2_col_out);
      d2_p2 <= d2_p1;
   end
   assign d2_col_in = d2_p2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      int lat2;
      int idx_in;
      int idx_out;
      int last_cyc;
      logic acc;

      n_checks = 0;
      n_errors = 0;
      st_a   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
      ex_a   = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
      st_b   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      ex_b   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      st_c   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
      ex_c   = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
      st_byp = 128'h00112233_44556677_8899aabb_ccddeeff;
      seq_in[0]  = st_a; seq_in[1]  = st_b; seq_in[2]  = st_c;
      seq_exp[0] = ex_a; seq_exp[1] = ex_b; seq_exp[2] = ex_c;

      rst_n = 1'b0;
      d0_in_valid = 1'b0; d0_in_bypass = 1'b0; d0_in_state = 128'd0; d0_out_ready = 1'b1;
      d2_in_valid = 1'b0; d2_in_bypass = 1'b0; d2_in_state = 128'd0; d2_out_ready = 1'b1;
      tick(); tick();

      // Reset state
      check_eq("rst_in_ready",  {127'd0, d0_in_ready}, 128'd1);
      check_eq("rst_out_valid", {127'd0, d0_out_valid}, 128'd0);
      check_eq("rst_col_issue", {127'd0, d0_col_issue}, 128'd0);
      check_eq("rst_col_out",   {96'd0, d0_col_out}, 128'd0);
      check_eq("rst_out_state", d0_out_state, 128'd0);
      check_eq("rst_busy",      {127'd0, d0_busy}, 128'd0);
      rst_n = 1'b1;
      tick();

      // Normal state, COL_LAT=0
      d0_in_state = st_a; d0_in_valid = 1'b1;
      tick();
      d0_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_eq("l0_issue", {127'd0, d0_col_issue}, 128'd1);
         check_eq("l0_col",   {96'd0, d0_col_out}, {96'd0, st_a[127-32*k -: 32]});
         check_eq("l0_novld", {127'd0, d0_out_valid}, 128'd0);
         tick();
      end
      check_eq("l0_valid", {127'd0, d0_out_valid}, 128'd1);
      check_eq("l0_state", d0_out_state, ex_a);
      check_eq("l0_issue_off", {127'd0, d0_col_issue}, 128'd0);
      tick();
      check_eq("l0_valid_drop", {127'd0, d0_out_valid}, 128'd0);
      check_eq("l0_ready_back", {127'd0, d0_in_ready}, 128'd1);

      // Bypass
      d0_in_state = st_byp; d0_in_bypass = 1'b1; d0_in_valid = 1'b1;
      tick();
      d0_in_valid = 1'b0; d0_in_bypass = 1'b0;
      check_eq("byp_valid", {127'd0, d0_out_valid}, 128'd1);
      check_eq("byp_state", d0_out_state, st_byp);
      check_eq("byp_issue", {127'd0, d0_col_issue}, 128'd0);
      tick();
      check_eq("byp_issue2", {127'd0, d0_col_issue}, 128'd0);
      check_eq("byp_idle",   {127'd0, d0_in_ready}, 128'd1);

      // COL_LAT=2 latency and result
      d2_in_state = st_b; d2_in_valid = 1'b1;
      tick();
      d2_in_valid = 1'b0;
      lat2 = 0;
      for (int n = 1; n <= 20 && lat2 == 0; n++) begin
         if (d2_out_valid) lat2 = n;
         else tick();
      end
      check_eq("l2_latency", lat2, 128'd7);
      check_eq("l2_state", d2_out_state, ex_b);
      tick();
      check_eq("l2_idle", {127'd0, d2_in_ready}, 128'd1);

      // Backpressure in DONE with a waiting new state
      d0_out_ready = 1'b0; d0_in_state = st_a; d0_in_valid = 1'b1;
      tick();
      d0_in_state = st_c;
      tick(); tick(); tick(); tick();
      for (int k = 0; k < 10; k++) begin
         check_eq("bp_valid", {127'd0, d0_out_valid}, 128'd1);
         check_eq("bp_state", d0_out_state, ex_a);
         check_eq("bp_ready", {127'd0, d0_in_ready}, 128'd0);
         tick();
      end
      d0_out_ready = 1'b1;
      check_eq("bp_still_valid", {127'd0, d0_out_valid}, 128'd1);
      tick();
      check_eq("bp_idle_ready", {127'd0, d0_in_ready}, 128'd1);
      check_eq("bp_idle_valid", {127'd0, d0_out_valid}, 128'd0);
      check_eq("bp_idle_busy",  {127'd0, d0_busy}, 128'd0);
      tick();
      d0_in_valid = 1'b0;
      check_eq("bp_new_busy", {127'd0, d0_busy}, 128'd1);
      check_eq("bp_new_col0", {96'd0, d0_col_out}, {96'd0, st_c[127:96]});
      tick(); tick(); tick(); tick();
      check_eq("bp_new_state", d0_out_state, ex_c);
      tick();

      // Reset during the third ISSUE cycle
      d0_in_state = st_a; d0_in_valid = 1'b1;
      tick();
      d0_in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check_eq("mr_issue", {127'd0, d0_col_issue}, 128'd0);
      check_eq("mr_col",   {96'd0, d0_col_out}, 128'd0);
      check_eq("mr_ready", {127'd0, d0_in_ready}, 128'd1);
      check_eq("mr_valid", {127'd0, d0_out_valid}, 128'd0);
      check_eq("mr_busy",  {127'd0, d0_busy}, 128'd0);
      check_eq("mr_state", d0_out_state, 128'd0);
      tick();
      rst_n = 1'b1;
      tick();
      d0_in_state = st_b; d0_in_valid = 1'b1;
      tick();
      d0_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_eq("mr_new_col", {96'd0, d0_col_out}, {96'd0, st_b[127-32*k -: 32]});
         tick();
      end
      check_eq("mr_new_valid", {127'd0, d0_out_valid}, 128'd1);
      check_eq("mr_new_state", d0_out_state, ex_b);
      tick();

      // Back-to-back, in_valid and out_ready held high
      idx_in = 0; idx_out = 0; last_cyc = 0;
      d0_in_state = seq_in[0]; d0_in_valid = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (d0_out_valid) begin
            if (idx_out < 3) begin
               check_eq("b2b_state", d0_out_state, seq_exp[idx_out]);
               if (idx_out > 0) check_eq("b2b_spacing", cyc - last_cyc, 128'd6);
            end else begin
               check_eq("b2b_extra", idx_out, 128'd2);
            end
            last_cyc = cyc;
            idx_out++;
         end
         acc = d0_in_ready && d0_in_valid;
         tick();
         if (acc) begin
            idx_in++;
            if (idx_in < 3) d0_in_state = seq_in[idx_in];
            else d0_in_valid = 1'b0;
         end
      end
      check_eq("b2b_count", idx_out, 128'd3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mixcol_sched.md
Name: mixcol_sched

Overview:
- Column scheduler for the AES encryption round. Accepts a 128-bit state over a valid/ready handshake and streams its four 32-bit columns, one per cycle, through the single shared MixColumns column unit.
- Captures each transformed column as it returns and presents the reassembled 128-bit state downstream.
- Supports a bypass for the final round, where MixColumns is skipped.

Parameters:
- COL_LAT, 0, pipeline latency of the attached column unit in cycles (0 = combinational; legal 0..3).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream state available
- in_ready  output  1  scheduler can accept a state
- in_state  input  128  state word; column c = in_state[127-32c -: 32]
- in_bypass  input  1  sampled with in_state; 1 = pass the state through untouched (final round)
- col_issue  output  1  column unit operand valid this cycle
- col_out  output  32  column operand to the column unit
- col_in  input  32  transformed column from the column unit, valid COL_LAT cycles after issue
- out_valid  output  1  result state available
- out_ready  input  1  downstream accepts result
- out_state  output  128  result state, same column ordering as in_state
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state IDLE; in_ready=1; out_valid=0; col_issue=0; col_out=0; out_state=0; busy=0.
  - Internal column counter, return counter and result register all cleared.
  - Reset mid-operation discards the in-flight state; no partial result is ever emitted.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready: latch in_state and in_bypass.
  - Next state is DONE if in_bypass=1; otherwise ISSUE with issue counter ic=0 and return counter rc=0.
- ISSUE:
  - col_issue=1, col_out = latched column ic; ic increments each cycle.
  - After the cycle with ic=3, go to DRAIN if COL_LAT>0, else DONE.
  - Exactly four consecutive issue cycles, columns in order 0,1,2,3.
- Return capture:
  - A COL_LAT-deep shift register of issue strobes marks returning columns.
  - On each return, col_in is written into result column rc and rc increments.
  - When COL_LAT=0, capture happens in the same cycle as the issue.
- DRAIN:
  - col_issue=0, col_out=0.
  - Go to DONE in the cycle after the fourth return is captured (rc wraps 3 to 0).
- DONE:
  - out_valid=1 and out_state = result register, or the latched in_state if bypass was set.
  - out_state is held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: go to IDLE, out_valid drops next cycle.
- Outside ISSUE: col_issue=0 and col_out=0.
- No overlap:
  - in_ready=0 in ISSUE, DRAIN and DONE.
  - A new state is accepted at the earliest one cycle after the output handshake.
- Latency, from accept edge to first out_valid cycle:
  - 5+COL_LAT cycles (normal).
  - 1 cycle (bypass).
- Throughput (normal, zero backpressure): one state per 6+COL_LAT cycles.
- Width rules: pure 32-bit lane routing, no arithmetic. Counters are 2 bits and wrap naturally.
- Protocol:
  - in_state and in_bypass are ignored unless the handshake fires.
  - in_valid may drop or change freely while in_ready=0.

Test Plan:
- COL_LAT=0, in_state=d4bf5d30_e0b452ae_b84111f1_1e2798e5, bypass=0, out_ready=1:
  - col_out = d4bf5d30, e0b452ae, b84111f1, 1e2798e5 on 4 consecutive cycles.
  - out_state = 046681e5_e0cb199a_48f8d37a_2806264c, out_valid 5 cycles after accept, held 1 cycle.
- Bypass=1, in_state=00112233_44556677_8899aabb_ccddeeff:
  - col_issue never asserts.
  - out_state equals in_state 1 cycle after accept.
- COL_LAT=2, in_state=db135345_f20a225c_01010101_c6c6c6c6:
  - out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 7 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with a new state:
  - out_state stable, in_ready=0 throughout, new state not accepted.
  - After out_ready=1: IDLE, then the new state is accepted on the following cycle.
- Reset mid-operation: drop rst_n during the third ISSUE cycle:
  - All outputs 0 immediately, in_ready=1, out_valid=0.
  - Next accepted state completes correctly with no stale columns.
- Back-to-back: 3 states with in_valid=1 and out_ready=1 constant:
  - Results in order, spaced 6+COL_LAT cycles apart, every column correct.
